// File: rtl/timebase_controller.sv
// Slow timebase: divides CLK_5_MHZ by one of four selectable periods and
// produces a 1-cycle tick enable plus a 50%-duty CLK_SLOW. A small
// IDLE/RUN/STEP controller lets downstream logic be run, paused or
// single-stepped. All outputs are registered.
module timebase_controller #(
  parameter int unsigned DIV0   = 2500000,
  parameter int unsigned DIV1   = 1250000,
  parameter int unsigned DIV2   = 500000,
  parameter int unsigned DIV3   = 5000,
  parameter int unsigned CNT_W  = 22,
  parameter int unsigned TCNT_W = 8
) (
  input  logic              CLK_5_MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic [1:0]        rate_sel,
  input  logic              rate_load,
  output logic              tick,
  output logic              CLK_SLOW,
  output logic              running,
  output logic [1:0]        rate_active,
  output logic [TCNT_W-1:0] tick_count
);

  localparam logic [CNT_W-1:0] P0M1 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] P1M1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] P2M1 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] P3M1 = CNT_W'(DIV3 - 1);

  typedef enum logic [1:0] {StIdle, StRun, StStep} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_m1;
  logic                tick_q, tick_d;
  logic                slow_q, slow_d;
  logic                running_q;
  logic [1:0]          rate_q, rate_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                at_end;
  logic                advance;

  // Terminal count for the currently applied rate.
  always_comb begin
    period_m1 = P0M1;
    unique case (rate_q)
      2'd0: period_m1 = P0M1;
      2'd1: period_m1 = P1M1;
      2'd2: period_m1 = P2M1;
      2'd3: period_m1 = P3M1;
      default: period_m1 = P0M1;
    endcase
  end

  assign at_end = (cnt_q == period_m1);

  // Command decode (stop > start > step), period counter and tick generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    slow_d  = slow_q;
    rate_d  = rate_q;
    tcnt_d  = tcnt_q;
    advance = 1'b0;

    if (rate_load) begin
      // A rate change restarts the period and swallows any coincident tick;
      // the controller state is left as it was.
      rate_d = rate_sel;
      cnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (stop) begin
            state_d = StIdle;
          end else if (start) begin
            state_d = StRun;
          end else if (step) begin
            state_d = StStep;
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            advance = 1'b1;
          end
        end
        StStep: begin
          if (stop) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            advance = 1'b1;
            // start upgrades a pending step to continuous run without a restart.
            if (start) begin
              state_d = StRun;
            end else if (at_end) begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase

      if (advance) begin
        if (at_end) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          slow_d = ~slow_q;
          tcnt_d = tcnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State and output registers; reset discards any partial period.
  always_ff @(posedge CLK_5_MHZ or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      slow_q    <= 1'b0;
      running_q <= 1'b0;
      rate_q    <= 2'd0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
      running_q <= (state_d != StIdle);
      rate_q    <= rate_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign tick        = tick_q;
  assign CLK_SLOW    = slow_q;
  assign running     = running_q;
  assign rate_active = rate_q;
  assign tick_count  = tcnt_q;

endmodule

// File: tb/tb_timebase_controller.sv
// Bench for timebase_controller with short periods. The reference model
// schedules each tick as an absolute edge number rather than tracking a counter.
module tb_timebase_controller;

  localparam int D0 = 4;
  localparam int D1 = 6;
  localparam int D2 = 10;
  localparam int D3 = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       rate_load = 1'b0;
  logic       tick;
  logic       CLK_SLOW;
  logic       running;
  logic [1:0] rate_active;
  logic [7:0] tick_count;
  logic [12:0] obs;

  int nv = 0;
  int nf = 0;

  // Reference model state
  int n = 0;
  int m_mode = 0;   // 0 idle, 1 run, 2 step
  int m_next = 0;   // edge number at which the next tick is due
  int m_rate = 0;
  int m_cnt = 0;
  bit m_tick = 1'b0;
  bit m_slow = 1'b0;

  timebase_controller #(
    .DIV0  (D0),
    .DIV1  (D1),
    .DIV2  (D2),
    .DIV3  (D3),
    .CNT_W (22),
    .TCNT_W(8)
  ) dut (
    .CLK_5_MHZ  (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .rate_sel   (rate_sel),
    .rate_load  (rate_load),
    .tick       (tick),
    .CLK_SLOW   (CLK_SLOW),
    .running    (running),
    .rate_active(rate_active),
    .tick_count (tick_count)
  );

  always #100 clk = ~clk;

  assign obs = {tick, CLK_SLOW, running, rate_active, tick_count};

  function automatic int divof(input int r);
    case (r)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [1:0] r;
    logic [7:0] c;
    r = m_rate[1:0];
    c = m_cnt[7:0];
    return {m_tick, m_slow, (m_mode != 0), r, c};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_next = 0;
    m_rate = 0;
    m_cnt  = 0;
    m_tick = 1'b0;
    m_slow = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, settle 1 time unit.
  task automatic clk_edge(input bit s, input bit p, input bit st, input bit ld,
                          input logic [1:0] sel);
    start = s;
    stop = p;
    step = st;
    rate_load = ld;
    rate_sel = sel;
    @(posedge clk);
    n++;
    m_tick = 1'b0;
    if (ld) begin
      m_rate = int'(sel);
      if (m_mode != 0) m_next = n + divof(m_rate);
    end else if (m_mode == 0) begin
      if (!p) begin
        if (s) begin
          m_mode = 1;
          m_next = n + divof(m_rate);
        end else if (st) begin
          m_mode = 2;
          m_next = n + divof(m_rate);
        end
      end
    end else if (p) begin
      m_mode = 0;
    end else begin
      if (m_mode == 2 && s) m_mode = 1;
      if (n == m_next) begin
        m_tick = 1'b1;
        m_slow = ~m_slow;
        m_cnt  = (m_cnt + 1) % 256;
        m_next = n + divof(m_rate);
        if (m_mode == 2) m_mode = 0;
      end
    end
    #1;
    start = 1'b0;
    stop = 1'b0;
    step = 1'b0;
    rate_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    nv++;
    if (obs !== 13'h0) begin
      nf++;
      $display("FAIL reset_state: got %h want %h", obs, 13'h0);
    end
    reset = 1'b1;
    clk_edge(0, 0, 0, 0, 2'd0);
    nv++;
    if (obs !== exp_vec()) begin
      nf++;
      $display("FAIL reset_release: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_run();
    clk_edge(1, 0, 0, 0, 2'd0);
    for (int i = 1; i <= 12; i++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      nv++;
      if (obs !== exp_vec() || tick !== (i % 4 == 0) || running !== 1'b1) begin
        nf++;
        $display("FAIL run_cycle%0d: got %h want %h tick_req %0d", i, obs, exp_vec(),
                 (i % 4 == 0));
      end
    end
    nv++;
    if (tick_count !== 8'd3 || CLK_SLOW !== 1'b1) begin
      nf++;
      $display("FAIL run_count: got cnt %0d slow %b want 3 1", tick_count, CLK_SLOW);
    end
  endtask

  task automatic test_stop_restart();
    clk_edge(0, 0, 0, 0, 2'd0);
    clk_edge(0, 1, 0, 0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      nv++;
      if (obs !== exp_vec() || tick !== 1'b0 || running !== 1'b0 ||
          tick_count !== 8'd3 || CLK_SLOW !== 1'b1) begin
        nf++;
        $display("FAIL stop_hold%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    clk_edge(1, 0, 0, 0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      nv++;
      if (obs !== exp_vec() || tick !== (i == 4)) begin
        nf++;
        $display("FAIL restart_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    clk_edge(0, 1, 0, 0, 2'd0);
  endtask

  task automatic test_step();
    int ticks;
    // plain step
    ticks = 0;
    clk_edge(0, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      ticks += int'(tick);
      nv++;
      if (obs !== exp_vec() || tick !== (i == 4)) begin
        nf++;
        $display("FAIL step_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    nv++;
    if (ticks != 1 || running !== 1'b0) begin
      nf++;
      $display("FAIL step_single: got %0d ticks run %b want 1 0", ticks, running);
    end
    // second step during STEP is ignored
    ticks = 0;
    clk_edge(0, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      clk_edge(0, 0, (i == 2), 0, 2'd0);
      ticks += int'(tick);
      nv++;
      if (obs !== exp_vec()) begin
        nf++;
        $display("FAIL step_twice%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    nv++;
    if (ticks != 1) begin
      nf++;
      $display("FAIL step_twice_count: got %0d want 1", ticks);
    end
    // stop during STEP gives no tick
    ticks = 0;
    clk_edge(0, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      clk_edge(0, (i == 2), 0, 0, 2'd0);
      ticks += int'(tick);
      nv++;
      if (obs !== exp_vec()) begin
        nf++;
        $display("FAIL step_stop%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    nv++;
    if (ticks != 0 || running !== 1'b0) begin
      nf++;
      $display("FAIL step_stop_count: got %0d ticks run %b want 0 0", ticks, running);
    end
  endtask

  task automatic test_rate_load();
    clk_edge(1, 0, 0, 0, 2'd0);
    for (int i = 1; i <= 3; i++) clk_edge(0, 0, 0, 0, 2'd0);
    clk_edge(0, 0, 0, 1, 2'd2);
    nv++;
    if (obs !== exp_vec() || tick !== 1'b0 || rate_active !== 2'd2) begin
      nf++;
      $display("FAIL rate_load_edge: got %h want %h", obs, exp_vec());
    end
    for (int j = 1; j <= 20; j++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      nv++;
      if (obs !== exp_vec() || tick !== (j % 10 == 0)) begin
        nf++;
        $display("FAIL rate_load_cycle%0d: got %h want %h", j, obs, exp_vec());
      end
    end
    clk_edge(0, 1, 0, 0, 2'd0);
    clk_edge(0, 0, 0, 1, 2'd0);
  endtask

  task automatic test_priority();
    int ticks;
    clk_edge(1, 1, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      nv++;
      if (obs !== exp_vec() || running !== 1'b0 || tick !== 1'b0) begin
        nf++;
        $display("FAIL prio_start_stop%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    ticks = 0;
    clk_edge(1, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      ticks += int'(tick);
      nv++;
      if (obs !== exp_vec() || running !== 1'b1) begin
        nf++;
        $display("FAIL prio_start_step%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    nv++;
    if (ticks != 2) begin
      nf++;
      $display("FAIL prio_run_ticks: got %0d want 2", ticks);
    end
    clk_edge(0, 1, 0, 0, 2'd0);
  endtask

  task automatic test_async_reset_wrap();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    clk_edge(1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 22; i++) clk_edge(0, 0, 0, 0, 2'd0);
    nv++;
    if (tick_count !== 8'd5 || obs !== exp_vec()) begin
      nf++;
      $display("FAIL pre_reset: got %h want cnt 5 model %h", obs, exp_vec());
    end
    #40;
    reset = 1'b0;
    #1;
    model_reset();
    nv++;
    if (obs !== 13'h0) begin
      nf++;
      $display("FAIL async_reset: got %h want %h", obs, 13'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    nv++;
    if (obs !== 13'h0) begin
      nf++;
      $display("FAIL reset_hold: got %h want %h", obs, 13'h0);
    end
    reset = 1'b1;
    clk_edge(0, 0, 0, 1, 2'd3);
    clk_edge(1, 0, 0, 0, 2'd0);
    for (int i = 1; i <= 260 * D3; i++) begin
      clk_edge(0, 0, 0, 0, 2'd0);
      nv++;
      if (obs !== exp_vec()) begin
        nf++;
        $display("FAIL wrap_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    nv++;
    if (tick_count !== 8'd4 || tick !== 1'b1) begin
      nf++;
      $display("FAIL wrap_count: got %0d tick %b want 4 1", tick_count, tick);
    end
    clk_edge(0, 1, 0, 0, 2'd0);
  endtask

  task automatic test_random();
    int r;
    bit s, p, st, ld;
    logic [1:0] sel;
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      s   = (r < 3) || (r == 10) || (r == 11);
      p   = (r >= 3 && r < 5) || (r == 10);
      st  = (r >= 5 && r < 8) || (r == 10) || (r == 11);
      ld  = (r >= 8 && r < 10);
      sel = 2'($urandom_range(0, 3));
      clk_edge(s, p, st, ld, sel);
      nv++;
      if (obs !== exp_vec()) begin
        nf++;
        $display("FAIL random%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop_restart();
    test_step();
    test_rate_load();
    test_priority();
    test_async_reset_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end

endmodule

// File: doc/timebase_controller.md
Name: timebase_controller

Overview:
Run-time controller for the board's slow timebase. Generates a 1-cycle tick enable and a 50%-duty slow clock (CLK_SLOW) from CLK_5_MHZ, with four selectable division rates. Supports start, stop and single-step commands, so LED/display logic downstream can be run, paused or stepped from debounced buttons. Sits between the button/switch input logic and every block that needs a slow enable.

Parameters:
DIV0, 2500000, period in clocks for rate_sel=0 (2 Hz ticks)
DIV1, 1250000, period for rate_sel=1 (4 Hz)
DIV2, 500000, period for rate_sel=2 (10 Hz)
DIV3, 5000, period for rate_sel=3 (1 kHz)
CNT_W, 22, period counter width; every DIVn must be in 2..2^CNT_W
TCNT_W, 8, tick_count width

Ports:
CLK_5_MHZ  in  1  system clock, 5 MHz
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  1-cycle pulse: begin continuous ticking
stop  in  1  1-cycle pulse: halt ticking
step  in  1  1-cycle pulse: produce exactly one tick, then halt
rate_sel  in  2  rate request, sampled only when rate_load=1
rate_load  in  1  1-cycle pulse: latch rate_sel into rate_active
tick  out  1  registered 1-cycle enable, once per period
CLK_SLOW  out  1  registered; toggles on every tick
running  out  1  1 in RUN or STEP state
rate_active  out  2  currently applied rate
tick_count  out  TCNT_W  ticks emitted since reset, wraps

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, tick=0, CLK_SLOW=0, running=0, rate_active=0, tick_count=0. Release is synchronous to CLK_5_MHZ. Reset mid-period discards the partial period.
- Period P = DIV[rate_active]. Counter counts 0..P-1 only in RUN/STEP and holds at 0 in IDLE.
- At the edge where the counter equals P-1 (RUN/STEP): counter<=0, tick<=1, CLK_SLOW<=~CLK_SLOW, tick_count<=tick_count+1 (mod 2^TCNT_W). Otherwise tick<=0.
- Tick spacing is exactly P cycles. The first tick is high in the cycle beginning P edges after the edge that sampled start/step.
- States:
  IDLE: start -> RUN; step -> STEP; counter cleared on entry.
  RUN: stop -> IDLE; start and step ignored (no counter restart).
  STEP: at the tick edge -> IDLE (tick still emitted); stop -> IDLE with no tick; start -> RUN, counter continues; step ignored.
- Command priority in the same cycle: stop > start > step.
- rate_load, in any state: rate_active<=rate_sel and counter<=0. If this coincides with a counter==P-1 edge, rate_load wins: no tick, no CLK_SLOW toggle, no tick_count increment. The state is unchanged.
- stop leaves CLK_SLOW at its current level and does not clear tick_count.
- running is registered and equals (state!=IDLE).
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Override DIV0=4, DIV1=6, DIV2=10, DIV3=3. Release reset, pulse start at edge 0 -> tick high at edges 4, 8, 12; CLK_SLOW 0->1->0->1; tick_count 1, 2, 3; running=1.
- In RUN at rate 0, pulse stop 2 cycles after a tick -> no further ticks, running=0, CLK_SLOW and tick_count hold. A later start gives its first tick 4 cycles after start.
- From IDLE, pulse step -> exactly one tick 4 cycles later, then running=0. A second step pulse during STEP is ignored (still one tick). stop during STEP -> zero ticks.
- In RUN, rate_load with rate_sel=2 in the same cycle the counter is 3 -> no tick that edge, rate_active=2, next tick 10 cycles later, then every 10.
- start+stop in the same cycle from IDLE -> stays IDLE. start+step -> RUN.
- Drive reset low mid-period with tick_count=5 -> all outputs 0 immediately, before the next clock edge. After release, 260 ticks at rate 3 -> tick_count=4 (wrap).
